alu_issue_stage: RTL
====================

// Module: alu_issue_stage
// PURPOSE
//   Decode/issue pipeline stage that produces the operation and operands consumed by the
//   RV32I ALU. Accepts OP-IMM, OP, LUI and AUIPC instructions with a valid/ready handshake
//   and reads the register file through combinational read ports. Registers
//   {alu_op, alu_in_0, alu_in_1, rd} into a 2-entry skid buffer, so the input side never
//   combinationally depends on out_ready. Sits between instruction fetch and execute.
// PARAMETERS
//   XLEN         32  data/instruction/PC width (only 32 supported)
//   SUPPRESS_X0   1  1: force rd_we=0 when rd==0
// PORTS
//   clk       in   1                    clock, all state on rising edge
//   rst       in   1                    synchronous reset, active-high
//   flush     in   1                    drop all buffered entries and the current input
//   in_valid  in   1                    instruction offered
//   in_ready  out  1                    stage can accept this cycle
//   in_insn   in   XLEN                 instruction word
//   in_pc     in   XLEN                 PC of in_insn
//   rs1_addr  out  5                    = in_insn[19:15], combinational
//   rs2_addr  out  5                    = in_insn[24:20], combinational
//   rs1_data  in   XLEN                 regfile read data for rs1_addr, same cycle
//   rs2_data  in   XLEN                 regfile read data for rs2_addr, same cycle
//   out_valid out  1                    head entry valid
//   out_ready in   1                    execute consumes head entry
//   alu_op    out  `DATA_WIDTH_ALU_OP   `ALU_OP_* code from define.v
//   alu_in_0  out  XLEN                 operand 0
//   alu_in_1  out  XLEN                 operand 1
//   rd_addr   out  5                    destination register
//   rd_we     out  1                    writeback enable
//   illegal   out  1                    head entry is an unsupported encoding
// BEHAVIOUR
//   - Occupancy FSM: EMPTY / ONE (head) / TWO (head+skid). in_ready = (state!=TWO) & !rst, registered.
//   - Accept = in_valid & in_ready & !flush. Drain = out_valid & out_ready.
//     EMPTY: accept->ONE. ONE: accept&!drain->TWO; !accept&drain->EMPTY; both->ONE (new head).
//     TWO: drain->ONE (skid moves to head, in order); no accept possible.
//   - Latency: accepted instruction is on outputs the cycle after acceptance; rs1/rs2_data sampled at accept.
//   - Head outputs hold stable while out_valid & !out_ready.
//   - Operand mapping (imm = sign-extended I-imm, shamt = insn[24:20] zero-extended):
//     OP-IMM (0010011): alu_in_0=imm (shamt for shifts), alu_in_1=rs1_data; ADDI/SLTI/SLTIU/ANDI/ORI/XORI/SLLI/SRLI/SRAI.
//     OP (0110011): alu_in_0=rs1_data, alu_in_1=rs2_data; ADD/SUB/SLT/SLTU/AND/OR/XOR/SLL/SRL/SRA.
//     LUI (0110111): alu_in_0={insn[31:12],12'b0}, alu_in_1=0.
//     AUIPC (0010111): alu_in_0={12'b0,insn[31:12]} (ALU shifts), alu_in_1=in_pc.
//   - Legal funct7: SLLI/SRLI/SLL/SRL/others 0000000; SRAI/SRA/SUB 0100000; all else illegal.
//   - Illegal/unsupported opcode: illegal=1, alu_op=`ALU_OP_ADD, operands 0, rd_we=0; still flows through handshake.
//   - rd_addr=insn[11:7]; rd_we=1 for legal, 0 if SUPPRESS_X0 & rd==0.
//   - flush: next cycle state=EMPTY, out_valid=0; input in flush cycle is not accepted; flush beats drain/accept.
//   - Reset (also mid-operation): state=EMPTY, out_valid=0, in_ready=0 during rst, 1 first cycle after;
//     alu_op=0, alu_in_0/1=0, rd_addr=0, rd_we=0, illegal=0.
// TESTING
//   - ADDI x1,x2,-5 (0xFFB10093), rs1_data=10, out_ready=1 -> next cycle alu_op=ADDI, in_0=0xFFFFFFFB, in_1=10, rd=1, rd_we=1.
//   - SUB x3,x4,x5 (0x405201B3), rs1=7, rs2=9 -> alu_op=SUB, in_0=7, in_1=9; same with funct7=0x01 -> illegal=1, rd_we=0.
//   - LUI x6,0x12345 -> in_0=0x12345000; AUIPC x7,0x12345 at pc=0x80 -> in_0=0x00012345, in_1=0x80.
//   - out_ready=0, 3 back-to-back insns -> two accepted, in_ready=0 from cycle 2, outputs stable; out_ready=1 -> drained in order, 3rd accepted.
//   - Flush while TWO with in_valid=1 -> next cycle out_valid=0, in_ready=1, input dropped; ADDI x0 -> rd_we=0.
//   - rst asserted in TWO -> next cycle all outputs 0, in_ready=0; rst released -> in_ready=1, EMPTY.

Source files
------------

// File: rtl/alu_issue_stage_if.sv
// Issue-stage bundle: fetch-side handshake, regfile read ports and ALU-side outputs.
// Pure wiring, no state.
// Directions follow the data: master drives the fetch/execute side, slave is the stage.

`ifndef ALU_OP_DEFINES
`define ALU_OP_DEFINES
`define DATA_WIDTH_ALU_OP 5
`define ALU_OP_ADD   5'd0
`define ALU_OP_SUB   5'd1
`define ALU_OP_SLL   5'd2
`define ALU_OP_SLT   5'd3
`define ALU_OP_SLTU  5'd4
`define ALU_OP_XOR   5'd5
`define ALU_OP_SRL   5'd6
`define ALU_OP_SRA   5'd7
`define ALU_OP_OR    5'd8
`define ALU_OP_AND   5'd9
`define ALU_OP_ADDI  5'd10
`define ALU_OP_SLTI  5'd11
`define ALU_OP_SLTIU 5'd12
`define ALU_OP_XORI  5'd13
`define ALU_OP_ORI   5'd14
`define ALU_OP_ANDI  5'd15
`define ALU_OP_SLLI  5'd16
`define ALU_OP_SRLI  5'd17
`define ALU_OP_SRAI  5'd18
`define ALU_OP_LUI   5'd19
`define ALU_OP_AUIPC 5'd20
`endif

interface alu_issue_stage_if #(
  parameter int XLEN = 32
);
  logic                          flush;
  logic                          in_valid;
  logic                          in_ready;
  logic [XLEN-1:0]               in_insn;
  logic [XLEN-1:0]               in_pc;
  logic [4:0]                    rs1_addr;
  logic [4:0]                    rs2_addr;
  logic [XLEN-1:0]               rs1_data;
  logic [XLEN-1:0]               rs2_data;
  logic                          out_valid;
  logic                          out_ready;
  logic [`DATA_WIDTH_ALU_OP-1:0] alu_op;
  logic [XLEN-1:0]               alu_in_0;
  logic [XLEN-1:0]               alu_in_1;
  logic [4:0]                    rd_addr;
  logic                          rd_we;
  logic                          illegal;

  modport master (
    output flush, in_valid, in_insn, in_pc, rs1_data, rs2_data, out_ready,
    input  in_ready, rs1_addr, rs2_addr, out_valid, alu_op, alu_in_0, alu_in_1,
           rd_addr, rd_we, illegal
  );

  modport slave (
    input  flush, in_valid, in_insn, in_pc, rs1_data, rs2_data, out_ready,
    output in_ready, rs1_addr, rs2_addr, out_valid, alu_op, alu_in_0, alu_in_1,
           rd_addr, rd_we, illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// RV32I ALU issue stage: decodes OP-IMM/OP/LUI/AUIPC into ALU op + operands.
// Latency 1: an accepted instruction appears on the outputs the next cycle.
// 2-entry skid buffer; in_ready is registered and never depends on out_ready.

module alu_issue_stage #(
  parameter int XLEN        = 32,
  parameter int SUPPRESS_X0 = 1
) (
  input logic         clk,
  input logic         rst,
  alu_issue_stage_if.slave bus
);

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [`DATA_WIDTH_ALU_OP-1:0] op;
    logic [XLEN-1:0]               in0;
    logic [XLEN-1:0]               in1;
    logic [4:0]                    rd;
    logic                          we;
    logic                          ill;
  } entry_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t state;
  entry_t head;
  entry_t skid;
  entry_t dec;
  logic   in_ready_q;
  logic   out_valid_q;
  logic   accept;
  logic   drain;

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] shamt;
  logic            legal;

  assign opc   = bus.in_insn[6:0];
  assign f3    = bus.in_insn[14:12];
  assign f7    = bus.in_insn[31:25];
  assign imm_i = {{(XLEN-12){bus.in_insn[31]}}, bus.in_insn[31:20]};
  assign shamt = {{(XLEN-5){1'b0}}, bus.in_insn[24:20]};

  assign bus.rs1_addr  = bus.in_insn[19:15];
  assign bus.rs2_addr  = bus.in_insn[24:20];
  // Reset gates in_ready immediately so nothing is taken during a reset cycle.
  assign bus.in_ready  = in_ready_q & ~rst;
  assign bus.out_valid = out_valid_q;
  assign bus.alu_op    = head.op;
  assign bus.alu_in_0  = head.in0;
  assign bus.alu_in_1  = head.in1;
  assign bus.rd_addr   = head.rd;
  assign bus.rd_we     = head.we;
  assign bus.illegal   = head.ill;

  assign accept = bus.in_valid & bus.in_ready & ~bus.flush;
  assign drain  = out_valid_q & bus.out_ready;

  // Decode the offered instruction into an entry, using the same-cycle regfile data.
  always_comb begin
    dec     = '0;
    dec.op  = `ALU_OP_ADD;
    dec.rd  = bus.in_insn[11:7];
    legal   = 1'b1;
    case (opc)
      OPC_OP_IMM: begin
        dec.in0 = imm_i;
        dec.in1 = bus.rs1_data;
        case (f3)
          3'b000: dec.op = `ALU_OP_ADDI;
          3'b010: dec.op = `ALU_OP_SLTI;
          3'b011: dec.op = `ALU_OP_SLTIU;
          3'b100: dec.op = `ALU_OP_XORI;
          3'b110: dec.op = `ALU_OP_ORI;
          3'b111: dec.op = `ALU_OP_ANDI;
          3'b001: begin
            dec.op  = `ALU_OP_SLLI;
            dec.in0 = shamt;
            legal   = (f7 == 7'b0000000);
          end
          default: begin
            dec.in0 = shamt;
            if (f7 == 7'b0000000)      dec.op = `ALU_OP_SRLI;
            else if (f7 == 7'b0100000) dec.op = `ALU_OP_SRAI;
            else                       legal  = 1'b0;
          end
        endcase
      end
      OPC_OP: begin
        dec.in0 = bus.rs1_data;
        dec.in1 = bus.rs2_data;
        case (f3)
          3'b000: begin
            if (f7 == 7'b0000000)      dec.op = `ALU_OP_ADD;
            else if (f7 == 7'b0100000) dec.op = `ALU_OP_SUB;
            else                       legal  = 1'b0;
          end
          3'b101: begin
            if (f7 == 7'b0000000)      dec.op = `ALU_OP_SRL;
            else if (f7 == 7'b0100000) dec.op = `ALU_OP_SRA;
            else                       legal  = 1'b0;
          end
          default: begin
            legal = (f7 == 7'b0000000);
            case (f3)
              3'b001:  dec.op = `ALU_OP_SLL;
              3'b010:  dec.op = `ALU_OP_SLT;
              3'b011:  dec.op = `ALU_OP_SLTU;
              3'b100:  dec.op = `ALU_OP_XOR;
              3'b110:  dec.op = `ALU_OP_OR;
              default: dec.op = `ALU_OP_AND;
            endcase
          end
        endcase
      end
      OPC_LUI: begin
        dec.op  = `ALU_OP_LUI;
        dec.in0 = {bus.in_insn[31:12], 12'b0};
        dec.in1 = '0;
      end
      OPC_AUIPC: begin
        // The ALU applies the 12-bit shift itself for AUIPC.
        dec.op  = `ALU_OP_AUIPC;
        dec.in0 = {{(XLEN-20){1'b0}}, bus.in_insn[31:12]};
        dec.in1 = bus.in_pc;
      end
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      dec.op  = `ALU_OP_ADD;
      dec.in0 = '0;
      dec.in1 = '0;
      dec.ill = 1'b1;
      dec.we  = 1'b0;
    end else begin
      dec.we  = !((SUPPRESS_X0 != 0) && (bus.in_insn[11:7] == 5'd0));
    end
  end

  // Occupancy FSM with head/skid storage; flush and reset empty it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_EMPTY;
      head        <= '0;
      skid        <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else if (bus.flush) begin
      state       <= S_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state)
        S_EMPTY: begin
          if (accept) begin
            head        <= dec;
            state       <= S_ONE;
            out_valid_q <= 1'b1;
          end
        end
        S_ONE: begin
          if (accept && drain) begin
            head <= dec;
          end else if (accept) begin
            skid       <= dec;
            state      <= S_TWO;
            in_ready_q <= 1'b0;
          end else if (drain) begin
            state       <= S_EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        S_TWO: begin
          if (drain) begin
            head       <= skid;
            state      <= S_ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state       <= S_EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule
